twos_complement_serial: RTL and testbench
=========================================

// Module: twos_complement_serial
// PURPOSE
//   Parametrised, multi-cycle two's-complement unit. It processes STEP bits per
//   clock and carries the ripple "seen-one" state between slices.
//   Supports pass, negate, absolute value and sign-magnitude-to-two's-complement.
//   Sits between operand capture and the arithmetic datapath, with valid/ready
//   handshakes on both sides.
// PARAMETERS
//   WIDTH  12  operand width in bits (>=2)
//   STEP    4  bits processed per cycle; WIDTH % STEP != 0 -> elaboration $error
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand/mode valid
//   in_ready   out  1      unit can accept (state IDLE and !rst)
//   in_data    in   WIDTH  operand
//   in_mode    in   2      00 pass, 01 negate, 10 abs, 11 sign-mag -> two's comp
//   out_valid  out  1      result valid; held until accepted
//   out_ready  in   1      downstream accepts result
//   out_data   out  WIDTH  result
//   busy       out  1      high in BUSY or DONE
//   ovf        out  1      overflow flag (only with TWOS_OVF_FLAG_EN)
// BEHAVIOUR
//   Reset: state IDLE; out_valid=0, out_data=0, busy=0, ovf=0, slice count=0,
//     seen=0. rst in any state aborts the operation and discards the operand.
//   FSM: IDLE -> BUSY on in_valid&&in_ready.
//     BUSY -> DONE on the edge that completes slice NSL-1, where NSL=WIDTH/STEP.
//     DONE -> IDLE on out_valid&&out_ready.
//   Accept edge: latch data, cnt=0, seen=0, inv flag:
//     00: inv=0
//     01: inv=1
//     10: inv=data[MSB]
//     11: inv=data[MSB], and data[MSB] is cleared before processing (magnitude only)
//   BUSY cycle k processes bits [k*STEP +: STEP], LSB first. For each bit b:
//     res = inv ? (b ^ seen) : b; then seen |= b.
//     seen ripples within the slice and is registered across slices.
//   Latency: out_valid rises NSL edges after the accept edge. With STEP==WIDTH
//     this is 1 edge.
//   in_ready=0 in BUSY/DONE; no overlapping operations.
//   out_data is stable while out_valid=1 and out_ready=0.
//   Boundaries:
//     - negating 0 gives 0, seen stays 0
//     - negate/abs of the most-negative value returns it unchanged
//     - mode 11 input 100..0 (negative zero) gives 0
//     - in_valid during reset is ignored
// CONFIGURATION
//   TWOS_OVF_FLAG_EN defined:
//     - ovf port exists; it is registered with out_data on the DONE transition
//       and cleared on output handshake or rst.
//     - ovf=1 iff mode 01/10 and the operand is 1 followed by WIDTH-1 zeros.
//   TWOS_OVF_FLAG_EN undefined: no ovf port; all other behaviour identical.
// TESTING (WIDTH=12, STEP=4 unless noted)
//   1. negate 0x001 -> out_data=0xFFF, out_valid 3 edges after accept, busy high
//      throughout.
//   2. abs 0xF9C -> 0x064; abs 0x064 -> 0x064; sign-mag 0x805 -> 0xFFB;
//      sign-mag 0x800 -> 0x000.
//   3. negate 0x800 -> 0x800 with ovf=1 (macro on); negate 0x000 -> 0x000 with
//      ovf=0.
//   4. Hold out_ready=0 for 5 cycles: out_valid and out_data stay fixed,
//      in_ready=0; one cycle after the handshake in_ready=1.
//   5. Assert rst during slice 1: next cycle state IDLE, out_valid=0,
//      out_data=0; a new operand completes correctly.
//   6. STEP=12: negate 0x3A5 -> 0xC5B in 1 edge. STEP=1: same result in 12
//      edges. Random sweep vs -in reference.

Source files
------------

// File: rtl/twos_complement_serial.sv
// Multi-cycle two's-complement unit (pass / negate / abs / sign-mag), STEP bits per clock.
// Define TWOS_OVF_FLAG_EN to add the ovf output flagging the most-negative operand.
module twos_complement_serial #(
  parameter int WIDTH = 12,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef TWOS_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSL   = WIDTH / STEP;
  localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSL - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WIDTH < 2) begin : g_bad_width
    $error("twos_complement_serial: WIDTH must be at least 2");
  end
  if (WIDTH % STEP != 0) begin : g_bad_step
    $error("twos_complement_serial: WIDTH must be a multiple of STEP");
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             seen;
  logic             inv;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] res_work;
  logic [WIDTH-1:0] res_next;
  logic [STEP-1:0]  slice_in;
  logic [STEP:0]    slice_out;
  int unsigned      base;
`ifdef TWOS_OVF_FLAG_EN
  logic             ovf_pend;
`endif

  // Ripple "seen-one" across a slice: bits are inverted only above the lowest set bit.
  function automatic logic [STEP:0] slice_conv(input logic [STEP-1:0] bits,
                                               input logic inv_f,
                                               input logic seen_f);
    logic            s;
    logic [STEP-1:0] r;
    s = seen_f;
    r = '0;
    for (int i = 0; i < STEP; i++) begin
      r[i] = inv_f ? (bits[i] ^ s) : bits[i];
      s    = s | bits[i];
    end
    return {s, r};
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    base      = int'(cnt) * STEP;
    slice_in  = opnd[base +: STEP];
    slice_out = slice_conv(slice_in, inv, seen);
    res_next  = res_work;
    res_next[base +: STEP] = slice_out[STEP-1:0];
  end

  // Operand capture and slice accumulation (no reset needed on pure data)
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      opnd <= (in_mode == 2'b11) ? {1'b0, in_data[WIDTH-2:0]} : in_data;
      inv  <= (in_mode == 2'b01) || (in_mode[1] && in_data[WIDTH-1]);
`ifdef TWOS_OVF_FLAG_EN
      ovf_pend <= ((in_mode == 2'b01) || (in_mode == 2'b10)) &&
                  (in_data == {1'b1, {(WIDTH-1){1'b0}}});
`endif
    end
    if (state == BUSY) begin
      res_work <= res_next;
    end
  end

  // Control FSM and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      seen     <= 1'b0;
      out_data <= '0;
`ifdef TWOS_OVF_FLAG_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= BUSY;
            cnt   <= '0;
            seen  <= 1'b0;
          end
        end
        BUSY: begin
          seen <= slice_out[STEP];
          if (cnt == LAST) begin
            state    <= DONE;
            cnt      <= '0;
            out_data <= res_next;
`ifdef TWOS_OVF_FLAG_EN
            ovf      <= ovf_pend;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
`ifdef TWOS_OVF_FLAG_EN
            ovf   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twos_complement_serial.sv
// Bench for twos_complement_serial: three instances (STEP 4, 12, 1) share the input side
// and are compared against an arithmetic reference of the four conversion modes.
module tb_twos_complement_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_data;
  logic [1:0]  in_mode;
  logic        out_ready;

  logic        rdy0, ov0, busy0, ovf0;
  logic        rdy1, ov1, busy1, ovf1;
  logic        rdy2, ov2, busy2, ovf2;
  logic [11:0] od0, od1, od2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  twos_complement_serial #(.WIDTH(12), .STEP(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .busy(busy0)
`ifdef TWOS_OVF_FLAG_EN
    , .ovf(ovf0)
`endif
  );

  twos_complement_serial #(.WIDTH(12), .STEP(12)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(busy1)
`ifdef TWOS_OVF_FLAG_EN
    , .ovf(ovf1)
`endif
  );

  twos_complement_serial #(.WIDTH(12), .STEP(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .busy(busy2)
`ifdef TWOS_OVF_FLAG_EN
    , .ovf(ovf2)
`endif
  );

`ifndef TWOS_OVF_FLAG_EN
  assign ovf0 = 1'b0;
  assign ovf1 = 1'b0;
  assign ovf2 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic modulo 2^12.
  function automatic logic [11:0] model(input logic [11:0] x, input logic [1:0] m);
    int v, neg, mag;
    v   = int'(x);
    neg = (4096 - v) % 4096;
    mag = v % 2048;
    case (m)
      2'b00:   return x;
      2'b01:   return 12'(neg);
      2'b10:   return (v >= 2048) ? 12'(neg) : x;
      default: return (v >= 2048) ? 12'((4096 - mag) % 4096) : 12'(mag);
    endcase
  endfunction

  function automatic logic model_ovf(input logic [11:0] x, input logic [1:0] m);
    return ((m == 2'b01) || (m == 2'b10)) && (x == 12'h800);
  endfunction

  task automatic do_op(input logic [11:0] x, input logic [1:0] m);
    int lat0, lat1, lat2;
    logic [11:0] d0, d1, d2;
    logic f0;
    logic busy_ok;
    lat0 = 0; lat1 = 0; lat2 = 0;
    d0 = '0; d1 = '0; d2 = '0; f0 = 1'b0;
    busy_ok = 1'b1;
    @(negedge clk);
    check($sformatf("in_ready %h/%0d", x, m), 32'({rdy0, rdy1, rdy2}), 32'h7);
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (lat0 == 0) begin
        if (!busy0) busy_ok = 1'b0;
        if (ov0) begin lat0 = n; d0 = od0; f0 = ovf0; end
      end
      if (lat1 == 0 && ov1) begin lat1 = n; d1 = od1; end
      if (lat2 == 0 && ov2) begin lat2 = n; d2 = od2; end
      if (lat0 != 0 && lat1 != 0 && lat2 != 0) break;
    end
    check($sformatf("s4_data %h/%0d", x, m), 32'(d0), 32'(model(x, m)));
    check($sformatf("s4_lat %h/%0d", x, m), lat0, 3);
    check($sformatf("s4_busy %h/%0d", x, m), 32'(busy_ok), 32'h1);
    check($sformatf("s12_data %h/%0d", x, m), 32'(d1), 32'(model(x, m)));
    check($sformatf("s12_lat %h/%0d", x, m), lat1, 1);
    check($sformatf("s1_data %h/%0d", x, m), 32'(d2), 32'(model(x, m)));
    check($sformatf("s1_lat %h/%0d", x, m), lat2, 12);
`ifdef TWOS_OVF_FLAG_EN
    check($sformatf("s4_ovf %h/%0d", x, m), 32'(f0), 32'(model_ovf(x, m)));
`endif
    // let the slowest instance complete its output handshake
    @(posedge clk);
  endtask

  initial begin
    logic [11:0] hd;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'({ov0, ov1, ov2}), 32'h0);
    check("rst_out_data", 32'(od0), 32'h0);
    check("rst_busy", 32'({busy0, busy1, busy2}), 32'h0);
    check("rst_in_ready", 32'({rdy0, rdy1, rdy2}), 32'h0);
    check("rst_ovf", 32'(ovf0), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    do_op(12'h001, 2'b01);
    do_op(12'hF9C, 2'b10);
    do_op(12'h064, 2'b10);
    do_op(12'h805, 2'b11);
    do_op(12'h800, 2'b11);
    do_op(12'h800, 2'b01);
    do_op(12'h000, 2'b01);
    do_op(12'h3A5, 2'b01);
    do_op(12'h800, 2'b10);
    do_op(12'h5C3, 2'b00);
    do_op(12'h123, 2'b11);

    // Backpressure: result must hold while out_ready is low
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 12'h9A3;
    in_mode   = 2'b01;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!ov0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold_lat", n, 3);
    hd = od0;
    check("hold_data", 32'(hd), 32'(model(12'h9A3, 2'b01)));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(ov0), 32'h1);
      check("hold_stable", 32'(od0), 32'(hd));
      check("hold_in_ready", 32'(rdy0), 32'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_out_valid", 32'(ov0), 32'h0);
    check("hs_in_ready", 32'(rdy0), 32'h1);
    repeat (12) @(posedge clk);

    // Reset in the middle of slice 1 aborts the operation
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'h456;
    in_mode  = 2'b01;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'({busy0, busy1, busy2}), 32'h0);
    check("abort_out_valid", 32'(ov0), 32'h0);
    check("abort_out_data", 32'(od0), 32'h0);
    check("abort_in_ready", 32'(rdy0), 32'h0);
    in_valid = 1'b1;
    in_data  = 12'h7FF;
    @(posedge clk);
    #1;
    check("rst_ignores_valid", 32'({busy0, busy1, busy2}), 32'h0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'({busy0, rdy0}), 32'h1);
    do_op(12'h456, 2'b01);

    for (int i = 0; i < 40; i++) begin
      do_op(12'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
